mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Arbitrates line-sized memory requests from the icache fetch stage and the dcache stage (the cache
//  stage's mem_req_* / arbiter_grant / fill_* interface) onto one synchronous main-memory port.
//  Models fixed memory latency with a counter. Returns line fills (reads) or acks (writes) to the winner.
//  Sits between both L1 caches and main_memory; one transaction in flight at a time.
// PARAMETERS
//  MEM_LATENCY       5    cycles from grant (cycle 1) to fill pulse (cycle MEM_LATENCY); legal >= 2
//  CACHE_LINE_WIDTH  128  line width in bits (from brisc_pkg)
//  ADDRESS_WIDTH     32   byte-address width (from brisc_pkg)
// PORTS
//  clk                  in   1     clock
//  reset                in   1     synchronous, active-high
//  icache_req_in        in   1     icache line-read request (level, held until fill)
//  icache_req_addr_in   in   AW    icache request byte address
//  dcache_req_in        in   1     dcache request (level, held until fill)
//  dcache_req_write_in  in   1     1 = dirty-line writeback, 0 = line read
//  dcache_req_addr_in   in   AW    dcache request byte address
//  dcache_req_data_in   in   CLW   writeback line data
//  icache_grant_out     out  1     icache owns the memory port
//  dcache_grant_out     out  1     dcache owns the memory port
//  icache_fill_out      out  1     1-cycle completion pulse to icache
//  dcache_fill_out      out  1     1-cycle completion pulse to dcache (read fill or write ack)
//  fill_addr_out        out  AW    line-aligned address of the completing transaction
//  fill_data_out        out  CLW   read line data (write: echoes the written data)
//  mem_en_out           out  1     memory access strobe, 1 cycle per transaction
//  mem_we_out           out  1     memory write enable (qualified by mem_en_out)
//  mem_addr_out         out  AW    line-aligned memory address
//  mem_wdata_out        out  CLW   memory write data
//  mem_rdata_in         in   CLW   memory read data, valid the cycle after mem_en_out
// BEHAVIOUR
//  - FSM: IDLE -> BUSY -> RESP -> IDLE. Arbitration happens only in IDLE.
//  - IDLE, any request: winner chosen and request (src, rw, addr, data) latched.
//    Addr latched with low log2(CLW/8) bits zeroed. cnt <= MEM_LATENCY-1, go BUSY.
//  - Winner selection: single requester wins. On a tie, round-robin: the source NOT granted last wins.
//    last_src resets to ICACHE, so the first tie goes to dcache.
//  - Grant is registered: high from the cycle after acceptance through the RESP cycle inclusive.
//    Grant is one-hot or zero.
//  - BUSY: cnt decrements each cycle. Cycle with cnt==1: mem_en_out=1, mem_we_out=latched rw,
//    mem_addr/wdata = latched values; next state RESP.
//  - RESP: winner's fill pulse=1; fill_addr_out = latched addr.
//    fill_data_out = mem_rdata_in (read) or latched data (write). Update last_src; next IDLE.
//  - Timeline, request seen cycle 0: grant cycles 1..MEM_LATENCY, mem_en cycle MEM_LATENCY-1,
//    fill cycle MEM_LATENCY.
//  - Next grant no earlier than cycle MEM_LATENCY+2.
//  - Request deassert/changes after acceptance are ignored. The transaction always completes.
//    The pipeline flush does not abort memory.
//  - Requester still high in the IDLE cycle after its fill is treated as a new request.
//  - Non-owner requests are held off silently. No fill pulse to the non-owner.
//  - Reset (incl. mid-transaction): state IDLE, cnt 0, last_src ICACHE.
//    All outputs 0 (grants, fills, fill_addr/data, mem_en/we/addr/wdata). No late fill or mem_en after reset.
//  - Outputs other than mem_* and fill_data are registered.
//    mem_* and fill_data_out are combinational from state/latches and mem_rdata_in.
// STRUCTURE
//  - brisc_pkg: arb_state_e {ARB_IDLE, ARB_BUSY, ARB_RESP}, arb_src_e {SRC_ICACHE, SRC_DCACHE},
//    MEM_LATENCY constant, and line-offset-width localparam.
//  - No sub-module inside. main_memory is a separate block instantiated beside this one at top level.
// TESTING
//  1. dcache read 0x0000_1044 alone at cycle 0 -> dcache_grant cycles 1..5; mem_en cycle 4, addr 0x1040, we=0;
//     mem_rdata=0xAA..AA -> dcache_fill cycle 5, data 0xAA..AA, addr 0x1040.
//  2. Both request at cycle 0 after reset -> dcache wins.
//     icache held ungranted until dcache fill; icache granted cycle 7, fill cycle 11.
//  3. Continuous requests from both for 4 transactions -> grants alternate D,I,D,I; no starvation.
//  4. dcache writeback addr 0x2000, data 0x1234..: mem_we=1 with wdata on mem_en cycle;
//     dcache_fill ack cycle 5, fill_data echoes data.
//  5. icache request dropped at cycle 2 of its transaction -> fill still issued cycle 5; FSM returns IDLE.
//  6. reset asserted cycle 3 of a transaction -> next cycle all outputs 0;
//     no mem_en/fill afterwards; new request after reset accepted normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and default geometry for the L1-to-main-memory arbiter.
// Winner selection is kept here so any block that needs it uses the same rule.
package mem_arbiter_pkg;

    localparam int unsigned ARB_MEM_LATENCY = 5;
    localparam int unsigned ARB_LINE_WIDTH  = 128;
    localparam int unsigned ARB_ADDR_WIDTH  = 32;
    localparam int unsigned ARB_LINE_OFF_W  = $clog2(ARB_LINE_WIDTH / 8);

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY,
        ARB_RESP
    } arb_state_e;

    typedef enum logic {
        SRC_ICACHE,
        SRC_DCACHE
    } arb_src_e;

    // A lone requester wins; on a tie the source not served last goes first.
    function automatic arb_src_e pick_winner(input logic i_req, input logic d_req,
                                             input arb_src_e last);
        arb_src_e w;
        if (i_req && d_req)
            w = (last == SRC_ICACHE) ? SRC_DCACHE : SRC_ICACHE;
        else if (d_req)
            w = SRC_DCACHE;
        else
            w = SRC_ICACHE;
        return w;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side request/grant/fill signals plus the main-memory port of the arbiter.
// slave = arbiter view, master = caches/memory view.
interface mem_arbiter_if #(
    parameter int unsigned AW  = 32,
    parameter int unsigned CLW = 128
);
    logic           icache_req_in;
    logic [AW-1:0]  icache_req_addr_in;
    logic           dcache_req_in;
    logic           dcache_req_write_in;
    logic [AW-1:0]  dcache_req_addr_in;
    logic [CLW-1:0] dcache_req_data_in;
    logic           icache_grant_out;
    logic           dcache_grant_out;
    logic           icache_fill_out;
    logic           dcache_fill_out;
    logic [AW-1:0]  fill_addr_out;
    logic [CLW-1:0] fill_data_out;
    logic           mem_en_out;
    logic           mem_we_out;
    logic [AW-1:0]  mem_addr_out;
    logic [CLW-1:0] mem_wdata_out;
    logic [CLW-1:0] mem_rdata_in;

    modport slave (
        input  icache_req_in, icache_req_addr_in,
        input  dcache_req_in, dcache_req_write_in, dcache_req_addr_in, dcache_req_data_in,
        output icache_grant_out, dcache_grant_out, icache_fill_out, dcache_fill_out,
        output fill_addr_out, fill_data_out,
        output mem_en_out, mem_we_out, mem_addr_out, mem_wdata_out,
        input  mem_rdata_in
    );

    modport master (
        output icache_req_in, icache_req_addr_in,
        output dcache_req_in, dcache_req_write_in, dcache_req_addr_in, dcache_req_data_in,
        input  icache_grant_out, dcache_grant_out, icache_fill_out, dcache_fill_out,
        input  fill_addr_out, fill_data_out,
        input  mem_en_out, mem_we_out, mem_addr_out, mem_wdata_out,
        output mem_rdata_in
    );

endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates icache/dcache line requests onto one fixed-latency memory port,
// one transaction in flight; returns fills (reads) or acks (writes) to the winner.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MEM_LATENCY      = ARB_MEM_LATENCY,
    parameter int unsigned CACHE_LINE_WIDTH = ARB_LINE_WIDTH,
    parameter int unsigned ADDRESS_WIDTH    = ARB_ADDR_WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    localparam int unsigned OFF_W = $clog2(CACHE_LINE_WIDTH / 8);
    localparam int unsigned CNT_W = $clog2(MEM_LATENCY + 1);
    localparam logic [ADDRESS_WIDTH-1:0] OFF_MASK =
        ADDRESS_WIDTH'((64'd1 << OFF_W) - 64'd1);

    typedef logic [CNT_W-1:0] cnt_t;

    arb_state_e                  state;
    cnt_t                        cnt;
    arb_src_e                    last_src;
    arb_src_e                    cur_src;
    logic                        cur_we;
    logic [ADDRESS_WIDTH-1:0]    cur_addr;
    logic [CACHE_LINE_WIDTH-1:0] cur_data;
    logic                        icache_grant;
    logic                        dcache_grant;
    logic                        icache_fill;
    logic                        dcache_fill;
    logic [ADDRESS_WIDTH-1:0]    fill_addr;
    arb_src_e                    winner;
    logic                        any_req;
    logic                        mem_fire;

    always_comb begin
        winner   = pick_winner(bus.icache_req_in, bus.dcache_req_in, last_src);
        any_req  = bus.icache_req_in | bus.dcache_req_in;
        mem_fire = (state == ARB_BUSY) && (cnt == cnt_t'(1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ARB_IDLE;
            cnt          <= '0;
            last_src     <= SRC_ICACHE;
            cur_src      <= SRC_ICACHE;
            cur_we       <= 1'b0;
            cur_addr     <= '0;
            cur_data     <= '0;
            icache_grant <= 1'b0;
            dcache_grant <= 1'b0;
            icache_fill  <= 1'b0;
            dcache_fill  <= 1'b0;
            fill_addr    <= '0;
        end else begin
            icache_fill <= 1'b0;
            dcache_fill <= 1'b0;
            fill_addr   <= '0;
            case (state)
                ARB_IDLE: begin
                    if (any_req) begin
                        cur_src <= winner;
                        if (winner == SRC_DCACHE) begin
                            cur_we   <= bus.dcache_req_write_in;
                            cur_addr <= bus.dcache_req_addr_in & ~OFF_MASK;
                            cur_data <= bus.dcache_req_data_in;
                        end else begin
                            cur_we   <= 1'b0;
                            cur_addr <= bus.icache_req_addr_in & ~OFF_MASK;
                            cur_data <= '0;
                        end
                        cnt          <= cnt_t'(MEM_LATENCY - 1);
                        icache_grant <= (winner == SRC_ICACHE);
                        dcache_grant <= (winner == SRC_DCACHE);
                        state        <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    cnt <= cnt - cnt_t'(1);
                    // The access cycle also arms the registered fill pulse for the next cycle.
                    if (cnt == cnt_t'(1)) begin
                        icache_fill <= (cur_src == SRC_ICACHE);
                        dcache_fill <= (cur_src == SRC_DCACHE);
                        fill_addr   <= cur_addr;
                        state       <= ARB_RESP;
                    end
                end
                ARB_RESP: begin
                    icache_grant <= 1'b0;
                    dcache_grant <= 1'b0;
                    last_src     <= cur_src;
                    state        <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.mem_en_out    = mem_fire;
        bus.mem_we_out    = mem_fire & cur_we;
        bus.mem_addr_out  = mem_fire ? cur_addr : '0;
        bus.mem_wdata_out = mem_fire ? cur_data : '0;
        bus.fill_data_out = '0;
        if (state == ARB_RESP)
            bus.fill_data_out = cur_we ? cur_data : bus.mem_rdata_in;
    end

    assign bus.icache_grant_out = icache_grant;
    assign bus.dcache_grant_out = dcache_grant;
    assign bus.icache_fill_out  = icache_fill;
    assign bus.dcache_fill_out  = dcache_fill;
    assign bus.fill_addr_out    = fill_addr;

endmodule
